// File: rtl/axis_out_pkg.sv
// Shared types and default geometry for the accelerator output unpacker.
package axis_out_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam int DEF_WORD_WIDTH_ACC = 32'sd32;
  localparam int DEF_S_DATA_WIDTH   = 32'sd128;
  localparam int DEF_ADDR_WIDTH     = 32'sd16;
  localparam int LANES              = DEF_S_DATA_WIDTH / DEF_WORD_WIDTH_ACC;

  // Lane index width, never narrower than one bit.
  function automatic int idx_width(input int lanes);
    return (lanes > 32'sd1) ? $clog2(lanes) : 32'sd1;
  endfunction

  localparam int LANE_IDX_W = idx_width(LANES);

endpackage

// File: rtl/axis_lane_pick.sv
// Lowest-set-bit encoder over a keep mask: lane index, one-hot clear mask and
// a flag telling whether that lane is the only one left.
module axis_lane_pick
  import axis_out_pkg::*;
#(
  parameter int N_LANES = LANES,
  parameter int IDX_W   = idx_width(N_LANES)
) (
  input  logic [N_LANES-1:0] keep,
  output logic [IDX_W-1:0]   lane,
  output logic [N_LANES-1:0] clr_mask,
  output logic               single
);

  // keep & -keep isolates the lowest set bit without a priority chain
  always_comb begin
    clr_mask = keep & (~keep + N_LANES'(1'b1));
    single   = (keep != '0) && (keep == clr_mask);
    lane     = '0;
    for (int i = 0; i < N_LANES; i++) begin
      lane = clr_mask[i] ? IDX_W'(i) : lane;
    end
  end

endmodule

// File: rtl/axis_output_unpacker.sv
// Serialises the kept lanes of wide accumulator beats into one addressed word
// per cycle and checks each packet's length against its descriptor.
module axis_output_unpacker
  import axis_out_pkg::*;
#(
  parameter int WORD_WIDTH_ACC = DEF_WORD_WIDTH_ACC,
  parameter int S_DATA_WIDTH   = DEF_S_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH
) (
  input  logic                                     aclk,
  input  logic                                     aresetn,
  input  logic                                     cfg_valid,
  output logic                                     cfg_ready,
  input  logic [ADDR_WIDTH-1:0]                    cfg_words,
  output logic                                     s_axis_tready,
  input  logic                                     s_axis_tvalid,
  input  logic                                     s_axis_tlast,
  input  logic [S_DATA_WIDTH-1:0]                  s_axis_tdata,
  input  logic [S_DATA_WIDTH/WORD_WIDTH_ACC-1:0]   s_axis_tkeep,
  output logic                                     m_valid,
  input  logic                                     m_ready,
  output logic [WORD_WIDTH_ACC-1:0]                m_data,
  output logic [ADDR_WIDTH-1:0]                    m_addr,
  output logic                                     m_last,
  output logic                                     done,
  output logic                                     err_len
);

  localparam int NL = S_DATA_WIDTH / WORD_WIDTH_ACC;
  localparam int IW = idx_width(NL);

  state_t                    state_r, state_nxt_s;
  logic [ADDR_WIDTH-1:0]     words_r, addr_r;
  logic                      err_r, done_r;
  logic [S_DATA_WIDTH-1:0]   buf_data_r;
  logic [NL-1:0]             buf_keep_r, cur_mask_r;
  logic                      buf_last_r, buf_valid_r, cur_single_r;
  logic [WORD_WIDTH_ACC-1:0] m_data_r;
  logic                      m_last_r;

  logic                      pop_s, reach_s, final_s, tready_s, s_hs_s, cfg_hs_s;
  logic [ADDR_WIDTH-1:0]     cnt_inc_s, count_now_s;
  logic                      done_nxt_s, err_set_s, load_s, flush_s;
  logic [S_DATA_WIDTH-1:0]   data_nxt_s;
  logic [NL-1:0]             keep_nxt_s, pick_mask_s;
  logic                      last_nxt_s, valid_nxt_s, m_last_nxt_s, pick_single_s;
  logic [IW-1:0]             pick_lane_s;
  logic [WORD_WIDTH_ACC-1:0] word_nxt_s;

  // The picker looks at next cycle's keep so the presented word is registered
  axis_lane_pick #(
    .N_LANES (NL),
    .IDX_W   (IW)
  ) u_pick (
    .keep     (keep_nxt_s),
    .lane     (pick_lane_s),
    .clr_mask (pick_mask_s),
    .single   (pick_single_s)
  );

  // Handshake terms; ready is withheld when the current word ends the packet
  always_comb begin
    pop_s       = buf_valid_r & m_ready;
    cnt_inc_s   = addr_r + ADDR_WIDTH'(1'b1);
    reach_s     = pop_s & (cnt_inc_s == words_r);
    final_s     = pop_s & cur_single_r & buf_last_r;
    count_now_s = pop_s ? cnt_inc_s : addr_r;
    tready_s    = 1'b0;
    case (state_r)
      RUN:     tready_s = ~buf_valid_r | (pop_s & cur_single_r & ~buf_last_r & ~reach_s);
      DROP:    tready_s = 1'b1;
      default: tready_s = 1'b0;
    endcase
    s_hs_s   = s_axis_tvalid & tready_s;
    cfg_hs_s = cfg_valid & (state_r == IDLE);
  end

  // Next-state, completion and length-error decisions
  always_comb begin
    state_nxt_s = state_r;
    done_nxt_s  = 1'b0;
    err_set_s   = 1'b0;
    load_s      = 1'b0;
    flush_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (cfg_hs_s) begin
          state_nxt_s = (cfg_words == '0) ? DROP : RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (final_s) begin
          done_nxt_s  = 1'b1;
          flush_s     = 1'b1;
          err_set_s   = (cnt_inc_s != words_r);
          state_nxt_s = IDLE;
        end else if (reach_s) begin
          // Count satisfied early: the rest of a tlast beat ends the packet now,
          // otherwise the remaining beats are swallowed in DROP.
          err_set_s   = 1'b1;
          flush_s     = 1'b1;
          done_nxt_s  = buf_last_r;
          state_nxt_s = buf_last_r ? IDLE : DROP;
        end else if (s_hs_s) begin
          if (s_axis_tkeep == '0) begin
            if (s_axis_tlast) begin
              done_nxt_s  = 1'b1;
              flush_s     = 1'b1;
              err_set_s   = (count_now_s != words_r);
              state_nxt_s = IDLE;
            end else begin
              state_nxt_s = RUN;
            end
          end else begin
            load_s = 1'b1;
          end
        end else begin
          state_nxt_s = RUN;
        end
      end
      DROP: begin
        if (s_hs_s) begin
          err_set_s = (s_axis_tkeep != '0);
          if (s_axis_tlast) begin
            done_nxt_s  = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = DROP;
          end
        end else begin
          state_nxt_s = DROP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        flush_s     = 1'b1;
      end
    endcase
  end

  // Next contents of the single-beat buffer
  always_comb begin
    data_nxt_s  = buf_data_r;
    keep_nxt_s  = buf_keep_r;
    last_nxt_s  = buf_last_r;
    valid_nxt_s = buf_valid_r;
    if (flush_s) begin
      keep_nxt_s  = '0;
      last_nxt_s  = 1'b0;
      valid_nxt_s = 1'b0;
    end else if (load_s) begin
      data_nxt_s  = s_axis_tdata;
      keep_nxt_s  = s_axis_tkeep;
      last_nxt_s  = s_axis_tlast;
      valid_nxt_s = 1'b1;
    end else if (pop_s) begin
      keep_nxt_s  = buf_keep_r & ~cur_mask_r;
      valid_nxt_s = ~cur_single_r;
    end else begin
      keep_nxt_s  = buf_keep_r;
    end
    m_last_nxt_s = valid_nxt_s & (count_now_s == words_r - ADDR_WIDTH'(1'b1));
  end

  // Lane multiplexer for the next presented word
  always_comb begin
    word_nxt_s = '0;
    for (int i = 0; i < NL; i++) begin
      word_nxt_s = (pick_lane_s == IW'(i)) ? data_nxt_s[i*WORD_WIDTH_ACC +: WORD_WIDTH_ACC]
                                           : word_nxt_s;
    end
  end

  // FSM state and one-cycle completion pulse
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= IDLE;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Descriptor, word counter and sticky length error
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      words_r <= '0;
      addr_r  <= '0;
      err_r   <= 1'b0;
    end else begin
      if (cfg_hs_s) begin
        words_r <= cfg_words;
        addr_r  <= '0;
      end else if (pop_s) begin
        addr_r  <= cnt_inc_s;
      end
      if (cfg_hs_s) begin
        err_r <= 1'b0;
      end else if (err_set_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Beat buffer plus the pre-decoded mask of the word being presented
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      buf_data_r   <= '0;
      buf_keep_r   <= '0;
      buf_last_r   <= 1'b0;
      buf_valid_r  <= 1'b0;
      cur_mask_r   <= '0;
      cur_single_r <= 1'b0;
      m_data_r     <= '0;
      m_last_r     <= 1'b0;
    end else begin
      buf_data_r   <= data_nxt_s;
      buf_keep_r   <= keep_nxt_s;
      buf_last_r   <= last_nxt_s;
      buf_valid_r  <= valid_nxt_s;
      cur_mask_r   <= pick_mask_s;
      cur_single_r <= pick_single_s;
      m_last_r     <= m_last_nxt_s;
      if (valid_nxt_s) begin
        m_data_r <= word_nxt_s;
      end
    end
  end

  assign cfg_ready     = (state_r == IDLE);
  assign s_axis_tready = tready_s;
  assign m_valid       = buf_valid_r;
  assign m_data        = m_data_r;
  assign m_addr        = addr_r;
  assign m_last        = m_last_r;
  assign done          = done_r;
  assign err_len       = err_r;

endmodule

// File: tb/tb_axis_output_unpacker.sv
// Randomised scoreboard bench for axis_output_unpacker with a lane-level packet model.
module tb_axis_output_unpacker;

  localparam int W  = 32;
  localparam int DW = 128;
  localparam int AW = 16;
  localparam int NL = 4;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [AW-1:0] cfg_words = '0;
  logic          s_axis_tready;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [NL-1:0] s_axis_tkeep = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [W-1:0]  m_data;
  logic [AW-1:0] m_addr;
  logic          m_last;
  logic          done;
  logic          err_len;

  axis_output_unpacker #(.WORD_WIDTH_ACC(W), .S_DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_words(cfg_words),
    .s_axis_tready(s_axis_tready), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_addr(m_addr),
    .m_last(m_last), .done(done), .err_len(err_len)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [AW-1:0] addr;
    logic          last;
  } word_t;

  word_t         exp_q[$];
  bit            exp_err_q[$];
  int            hs_cyc[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            done_cnt = 0;
  int            cyc = 0;
  int            rdy_mode = 0;
  bit            held = 0;
  word_t         held_w;
  word_t         mon_w;
  logic [DW-1:0] bd[16];
  logic [NL-1:0] bk[16];
  bit            bl[16];

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual %0h required none (t=%0t)", name, act, $time);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // m_ready driver: always ready, 50% random, or stalled
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Monitor: sample half a cycle away from the active edge
  initial begin
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        held = 0;
      end else begin
        mon_w = {m_data, m_addr, m_last};
        if (held) check("stall_stable", {m_valid, mon_w}, {1'b1, held_w});
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) fail_now("unexpected_word", mon_w);
          else check("word", mon_w, exp_q.pop_front());
          hs_cyc.push_back(cyc);
          held = 0;
        end else if (m_valid) begin
          held   = 1;
          held_w = mon_w;
        end else begin
          held = 0;
        end
        if (done) begin
          if (exp_err_q.size() == 0) fail_now("unexpected_done", err_len);
          else check("err_len_at_done", err_len, exp_err_q.pop_front());
          done_cnt++;
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_cfg_ready"}, cfg_ready, 1);
    check({tag, "_tready"}, s_axis_tready, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_data"}, m_data, 0);
    check({tag, "_m_addr"}, m_addr, 0);
    check({tag, "_m_last"}, m_last, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err_len"}, err_len, 0);
  endtask

  task automatic do_cfg(input int n);
    bit acc = 0;
    int guard = 0;
    cfg_valid = 1'b1;
    cfg_words = AW'(n);
    while (!acc && guard < 100) begin
      @(negedge aclk);
      acc = cfg_ready;
      tick();
      guard++;
    end
    cfg_valid = 1'b0;
    if (!acc) fail_now("cfg_timeout", guard);
    else check("err_cleared_on_cfg", err_len, 0);
  endtask

  task automatic do_beat(input int b);
    bit acc = 0;
    int guard = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = bd[b];
    s_axis_tkeep  = bk[b];
    s_axis_tlast  = bl[b];
    while (!acc && guard < 500) begin
      @(negedge aclk);
      acc = s_axis_tready;
      tick();
      guard++;
    end
    s_axis_tvalid = 1'b0;
    if (!acc) fail_now("beat_timeout", b);
  endtask

  // Reference: walk kept lanes in order, emit until the count is met, flag length errors
  task automatic run_packet(input int n, input int nb, input bit gaps);
    int    count = 0;
    bit    err = 0;
    bit    stopped = (n == 0);
    int    hi;
    int    target;
    int    guard = 0;
    word_t w;
    for (int b = 0; b < nb; b++) begin
      hi = -1;
      for (int l = 0; l < NL; l++) if (bk[b][l]) hi = l;
      for (int l = 0; l < NL; l++) begin
        if (bk[b][l]) begin
          if (stopped) begin
            err = 1;
          end else begin
            w.data = bd[b][l*W +: W];
            w.addr = AW'(count);
            w.last = (count == n - 1);
            exp_q.push_back(w);
            count++;
            if (count == n) begin
              stopped = 1;
              if (!(bl[b] && l == hi)) err = 1;
            end
          end
        end
      end
      if (bl[b] && !stopped && count != n) err = 1;
    end
    exp_err_q.push_back(err);
    target = done_cnt + 1;
    do_cfg(n);
    for (int b = 0; b < nb; b++) begin
      do_beat(b);
      if (gaps && $urandom_range(0, 3) == 0) tick();
    end
    while (done_cnt < target && guard < 2000) begin
      tick();
      guard++;
    end
    if (done_cnt < target) fail_now("done_timeout", done_cnt);
  endtask

  task automatic fill_data(input int nb);
    for (int b = 0; b < nb; b++) bd[b] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    int nb;
    int total;
    repeat (3) @(posedge aclk);
    #1;
    check_reset_vals("in_reset");
    aresetn = 1'b1;
    tick();
    check_reset_vals("after_reset");

    // Two full beats, exact length
    rdy_mode = 0;
    fill_data(2);
    bk[0] = 4'hF; bl[0] = 0;
    bk[1] = 4'hF; bl[1] = 1;
    run_packet(8, 2, 0);

    // Sparse keep, words must stream without bubbles
    hs_cyc.delete();
    fill_data(2);
    bk[0] = 4'b1010; bl[0] = 0;
    bk[1] = 4'b0101; bl[1] = 1;
    run_packet(4, 2, 0);
    check("sparse_word_count", hs_cyc.size(), 4);
    if (hs_cyc.size() == 4) check("sparse_no_bubble_span", hs_cyc[3] - hs_cyc[0], 3);

    // 64 words under random backpressure
    rdy_mode = 1;
    fill_data(16);
    for (int b = 0; b < 16; b++) begin
      bk[b] = 4'hF;
      bl[b] = (b == 15);
    end
    run_packet(64, 16, 1);

    // Count met early: second beat dropped
    rdy_mode = 0;
    fill_data(2);
    bk[0] = 4'hF; bl[0] = 0;
    bk[1] = 4'hF; bl[1] = 1;
    run_packet(4, 2, 0);

    // Packet short of its count; error sticky until the next descriptor
    fill_data(1);
    bk[0] = 4'hF; bl[0] = 1;
    run_packet(8, 1, 0);
    check("err_sticky_idle", err_len, 1);
    fill_data(1);
    run_packet(4, 1, 0);

    // Reset with a full buffer and a stalled word
    rdy_mode = 2;
    tick();
    fill_data(1);
    bk[0] = 4'hF; bl[0] = 0;
    do_cfg(8);
    do_beat(0);
    repeat (3) tick();
    check("m_valid_before_reset", m_valid, 1);
    #2 aresetn = 1'b0;
    #1 check_reset_vals("mid_packet_reset");
    exp_q.delete();
    exp_err_q.delete();
    repeat (2) tick();
    aresetn = 1'b1;
    rdy_mode = 0;
    tick();
    check_reset_vals("post_mid_reset");
    fill_data(2);
    bk[0] = 4'hF; bl[0] = 0;
    bk[1] = 4'hF; bl[1] = 1;
    run_packet(8, 2, 0);

    // Random packets: random keep, lengths around the kept-lane total
    for (int p = 0; p < 25; p++) begin
      rdy_mode = $urandom_range(0, 1);
      nb = $urandom_range(1, 5);
      total = 0;
      fill_data(nb);
      for (int b = 0; b < nb; b++) begin
        bk[b] = NL'($urandom_range(0, 15));
        bl[b] = (b == nb - 1);
        total += $countones(bk[b]);
      end
      run_packet($urandom_range(0, total + 2), nb, 1);
    end

    rdy_mode = 0;
    repeat (4) tick();
    check("word_queue_drained", exp_q.size(), 0);
    check("done_queue_drained", exp_err_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached with %0d failures", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
